// File: rtl/r_result_serializer_if.sv
// Output stream interface for r_result_serializer.
// Valid/ready handshake: the master raises out_valid with out_word and
// out_last stable; a word moves on every rising clk edge where both
// out_valid and out_ready are 1. While out_ready is 0 the master holds
// out_word/out_last unchanged. out_ready has no meaning while out_valid is 0.
interface r_result_serializer_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_word,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_word,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/r_result_serializer.sv
// r_result_serializer: captures the RSA core's wide result in one cycle and
// streams it out as WORD_W-bit words over a valid/ready handshake.
// Optional build macro R_SER_MSW_FIRST_EN: when defined, words leave
// most-significant first; otherwise least-significant first.
// Handshake rules are documented on r_result_serializer_if.
module r_result_serializer #(
    parameter int DATA_W = 512,
    parameter int WORD_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      res_in,
    input  logic                   res_valid,
    r_result_serializer_if.master  ob,
    output logic                   busy,
    output logic                   overflow,
    output logic                   state_dbg
);
    localparam int NWORDS = DATA_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] sreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;

    logic              xfer;
    logic              at_last;
    logic              final_xfer;
    logic              load;
    logic              ovf_set;
    logic [WORD_W-1:0] cur_word;

    // Select the word presented from the shift register for this build.
`ifdef R_SER_MSW_FIRST_EN
    assign cur_word = sreg_q[DATA_W-1 -: WORD_W];
`else
    assign cur_word = sreg_q[WORD_W-1:0];
`endif

    // State register; reset abandons any stream in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. A new result may only be taken in
    // IDLE or on the same edge that the final word leaves, so a reload
    // right at the end of a stream costs no bubble cycle.
    always_comb begin
        state_d     = state_q;
        xfer        = 1'b0;
        at_last     = 1'b0;
        final_xfer  = 1'b0;
        load        = 1'b0;
        ovf_set     = 1'b0;
        ob.out_word = '0;
        ob.out_valid = 1'b0;
        ob.out_last = 1'b0;
        busy        = 1'b0;

        case (state_q)
            IDLE: begin
                if (res_valid) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                ob.out_valid = 1'b1;
                busy         = 1'b1;
                ob.out_word  = cur_word;
                at_last      = (cnt_q == LAST_CNT);
                ob.out_last  = at_last;
                xfer         = ob.out_ready;
                final_xfer   = xfer && at_last;
                if (final_xfer) begin
                    if (res_valid) begin
                        load    = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (res_valid) begin
                    // Result arrived mid-stream: dropped and flagged.
                    ovf_set = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift register and word counter: load on capture, advance one word
    // per transfer, hold otherwise so nothing is skipped or repeated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            sreg_q <= res_in;
            cnt_q  <= '0;
        end else if (xfer) begin
`ifdef R_SER_MSW_FIRST_EN
            sreg_q <= sreg_q << WORD_W;
`else
            sreg_q <= sreg_q >> WORD_W;
`endif
            // The counter wraps to zero after the last word so it never
            // exceeds NWORDS-1 and is ready for the next result.
            if (at_last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_r_result_serializer.sv
// Directed testbench for r_result_serializer. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
// Defining R_SER_MSW_FIRST_EN reverses the expected word order.
module tb_r_result_serializer;
    localparam int DATA_W = 512;
    localparam int WORD_W = 32;
    localparam int NWORDS = DATA_W / WORD_W;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] res_in;
    logic              res_valid;
    logic              busy;
    logic              overflow;
    logic              state_dbg;

    int compared;
    int mismatched;

    r_result_serializer_if #(.WORD_W(WORD_W)) ob_if ();

    r_result_serializer #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_in    (res_in),
        .res_valid (res_valid),
        .ob        (ob_if.master),
        .busy      (busy),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Result whose word k holds base + k.
    function automatic logic [DATA_W-1:0] make_res(input logic [WORD_W-1:0] base);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < NWORDS; k++) begin
            r[k*WORD_W +: WORD_W] = base + WORD_W'(k);
        end
        return r;
    endfunction

    // Expected i-th emitted word of a make_res(base) result.
    function automatic logic [WORD_W-1:0] exp_word(input logic [WORD_W-1:0] base, input int i);
`ifdef R_SER_MSW_FIRST_EN
        return base + WORD_W'(NWORDS - 1 - i);
`else
        return base + WORD_W'(i);
`endif
    endfunction

    task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one presented word of a stream.
    task automatic check_word(input string tag, input logic [WORD_W-1:0] base, input int i);
        check({tag, "_valid"}, WORD_W'(ob_if.out_valid), 1);
        check({tag, "_busy"}, WORD_W'(busy), 1);
        check({tag, "_word"}, ob_if.out_word, exp_word(base, i));
        check({tag, "_last"}, WORD_W'(ob_if.out_last), WORD_W'(i == NWORDS - 1));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, WORD_W'(ob_if.out_valid), 0);
        check({tag, "_busy"}, WORD_W'(busy), 0);
        check({tag, "_state"}, WORD_W'(state_dbg), 0);
    endtask

    localparam logic [WORD_W-1:0] P1 = 32'h1000_0000;
    localparam logic [WORD_W-1:0] P3 = 32'hA5A5_0000;
    localparam logic [WORD_W-1:0] P0 = 32'h0000_0000;

    initial begin
        int idx;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        res_in     = '0;
        res_valid  = 1'b0;
        ob_if.out_ready = 1'b0;

        // Reset state.
        #2;
        check_idle("reset");
        check("reset_word", ob_if.out_word, 0);
        check("reset_last", WORD_W'(ob_if.out_last), 0);
        check("reset_ovf", WORD_W'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: full stream with out_ready held high.
        res_in = make_res(P1);
        res_valid = 1'b1;
        ob_if.out_ready = 1'b1;
        check_idle("t1_pre");
        @(negedge clk);
        res_valid = 1'b0;
        for (int k = 0; k < NWORDS; k++) begin
            check_word("t1", P1, k);
            @(negedge clk);
        end
        check_idle("t1_end");
        check("t1_ovf", WORD_W'(overflow), 0);

        // Test 2: out_ready pattern 1,0,0 repeating; words must hold.
        res_in = make_res(P1);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 100; c++) begin
            ob_if.out_ready = (c % 3 == 0);
            check_word("t2", P1, idx);
            if (ob_if.out_ready) idx++;
            if (idx == NWORDS) break;
            @(negedge clk);
        end
        check("t2_count", WORD_W'(idx), WORD_W'(NWORDS));
        @(negedge clk);
        check_idle("t2_end");

        // Test 3: new result on the final transfer, no bubble.
        ob_if.out_ready = 1'b1;
        res_in = make_res(P1);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int k = 0; k < NWORDS; k++) begin
            check_word("t3a", P1, k);
            if (k == NWORDS - 1) begin
                res_in = make_res(P3);
                res_valid = 1'b1;
            end
            @(negedge clk);
        end
        res_valid = 1'b0;
        for (int k = 0; k < NWORDS; k++) begin
            check_word("t3b", P3, k);
            check("t3b_ovf", WORD_W'(overflow), 0);
            @(negedge clk);
        end
        check_idle("t3_end");

        // Test 4: result during word 5 is dropped and flags overflow.
        res_in = make_res(P1);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int k = 0; k < NWORDS; k++) begin
            check_word("t4", P1, k);
            if (k == 5) begin
                res_in = make_res(P3);
                res_valid = 1'b1;
            end else begin
                res_valid = 1'b0;
            end
            @(negedge clk);
        end
        res_valid = 1'b0;
        check_idle("t4_end");
        check("t4_ovf", WORD_W'(overflow), 1);
        @(negedge clk);
        @(negedge clk);
        check("t4_ovf_hold", WORD_W'(overflow), 1);

        // Test 5: asynchronous reset while word 8 is presented.
        res_in = make_res(P1);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_word("t5", P1, k);
            @(negedge clk);
        end
        check_word("t5_w8", P1, 8);
        #2;
        rst = 1'b1;
        #1;
        check_idle("t5_rst");
        check("t5_rst_word", ob_if.out_word, 0);
        check("t5_rst_ovf", WORD_W'(overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle("t5_after");
        end

        // Test 6: word k = k, also the ordering check for the MSW build.
        res_in = make_res(P0);
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        for (int k = 0; k < NWORDS; k++) begin
            check_word("t6", P0, k);
            @(negedge clk);
        end
        check_idle("t6_end");
        check("t6_ovf", WORD_W'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/r_result_serializer.md
Name: r_result_serializer

Overview:
- Downstream stage of the 512-bit RSA inverse/CRT core.
- Captures the core's wide result in a single cycle when the core signals completion.
- Streams the result out as WORD_W-bit words over a valid/ready handshake, mirroring the 32-bit word-serial loading on the input side of the core.
- Sits between the core's result register and the 32-bit external output bus.

Parameters:
- DATA_W, 512, width of the captured result; must be an integer multiple of WORD_W.
- WORD_W, 32, width of each output word.
- NWORDS, DATA_W/WORD_W (derived localparam, 16), words per result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- res_in  input  DATA_W  result from core; sampled only when res_valid=1.
- res_valid  input  1  one-cycle completion pulse from core.
- out_word  output  WORD_W  current output word.
- out_valid  output  1  out_word holds a valid word.
- out_ready  input  1  downstream accepts out_word this cycle.
- out_last  output  1  high with out_valid on the final word (index NWORDS-1).
- busy  output  1  high while a result is being transmitted.
- overflow  output  1  sticky; a result arrived while busy and was dropped.

Behaviour:
- Reset: one clock and one asynchronous, active-high reset (clk, rst); no synchronous reset path.
  - On rst=1, immediately: state=IDLE; shift register=0; word count=0.
  - Outputs: out_word=0, out_valid=0, out_last=0, busy=0, overflow=0.
  - Reset mid-transfer abandons the result; no further words are emitted.
- State machine has two states, IDLE and SEND.
- IDLE:
  - out_valid=0, busy=0.
  - On res_valid=1: load res_in into the shift register, count=0, next state SEND.
  - Latency: word 0 appears with out_valid=1 on the cycle after res_valid.
- SEND:
  - out_valid=1, busy=1.
  - out_word = shift register[WORD_W-1:0], i.e. least-significant word first (index 0 = res_in[31:0]).
  - A transfer occurs on a cycle where out_valid=1 and out_ready=1.
  - On a transfer: shift register shifts right by WORD_W with zero fill; count increments.
  - With out_ready=0: out_word, out_last and count hold stable; no word is skipped or repeated.
  - out_last = (count == NWORDS-1).
  - A transfer while out_last=1 ends the result: next state IDLE, out_valid=0 next cycle.
  - Back-to-back transfers: one word per cycle with out_ready held high, so a full result takes NWORDS cycles.
- Simultaneous events:
  - res_valid on the same cycle as the final transfer: the new result is accepted; state stays SEND, count=0, and the new word 0 is presented the next cycle (no bubble).
  - res_valid in SEND at any other time: input ignored, current stream continues unchanged, overflow set to 1 and held until rst.
- Counter width is $clog2(NWORDS); it never exceeds NWORDS-1.
- out_ready is a don't-care in IDLE.

Optional Feature:
- Macro: R_SER_MSW_FIRST_EN.
- Defined:
  - Words are emitted most-significant first: word 0 = res_in[DATA_W-1:DATA_W-WORD_W].
  - The shift register shifts left; out_word = shift register[DATA_W-1:DATA_W-WORD_W].
  - out_last still marks the NWORDS-th word.
- Undefined: LSW-first ordering as in Behaviour.
- Handshake, latency, overflow and reset behaviour are identical in both builds.

Test Plan:
- Reset, then res_valid pulse with res_in word k = 32'h1000_0000+k, out_ready=1 → next cycle out_word=32'h1000_0000; 16 consecutive words 32'h1000_0000..32'h1000_000F; out_last only on 32'h1000_000F; out_valid=0 the cycle after.
- Same load with out_ready toggling 1,0,0,1,... → each word held stable while out_ready=0; exactly 16 transfers in order, none duplicated.
- Second res_valid (pattern 32'hA5A5_0000+k) on the cycle of the final transfer → first word of the new stream, 32'hA5A5_0000, on the next cycle; busy stays 1; overflow=0.
- res_valid during transfer of word 5 → original stream completes unchanged; overflow=1 and still 1 after returning to IDLE; cleared only by rst.
- Assert rst asynchronously (between clock edges) during word 8 → out_valid, busy, out_word go to 0 immediately; after release, state is IDLE and no words are emitted until the next res_valid.
- With R_SER_MSW_FIRST_EN defined, res_in = {32'hF,32'hE,...,32'h0} (word k = k) → output order 32'hF down to 32'h0; out_last on 32'h0.
